slice_pack_sequencer: RTL and testbench
=======================================

// Module: slice_pack_sequencer
// PURPOSE
//  Sequencer for the dynamic set-slice datapath. Accepts a stream of FIELD_W-bit
//  fields, each with a runtime bit offset, and writes them into a WORD_W-bit
//  accumulator pre-filled with FILL. The assembled word is emitted on a
//  valid/ready output when the field marked last is accepted.
//  Sits between field producers (header/descriptor builders) and word-wide sinks.
// PARAMETERS
//  WORD_W   12  accumulator/output width
//  FIELD_W  6   input field width
//  OFF_W    2   offset width; offsets 0..2^OFF_W-1
//  CNT_W    4   field-count width (saturating)
//  FILL     1   value of every unwritten bit (1'b0 or 1'b1)
//  Legality: (2^OFF_W-1)+FIELD_W <= WORD_W, so every offset is in range; elaboration error otherwise.
// PORTS
//  CLK          in   1        clock, rising edge
//  ASYNCRESET   in   1        asynchronous, active-high reset
//  in_valid     in   1        field offered
//  in_ready     out  1        block accepts field this cycle
//  in_field     in   FIELD_W  field data
//  in_off       in   OFF_W    LSB position of field in word (unsigned)
//  in_last      in   1        field closes the current word
//  out_valid    out  1        assembled word available
//  out_ready    in   1        sink accepts word
//  out_word     out  WORD_W   assembled word
//  out_count    out  CNT_W    fields written into out_word (saturates at 2^CNT_W-1)
//  out_overlap  out  1        some written bit was overwritten by a later field
// BEHAVIOUR
//  Reset (async assert, sync release): state=ACCUM, acc={WORD_W{FILL}}, mask=0,
//   count=0, ovl=0, out_valid=0, out_word={WORD_W{FILL}}, out_count=0, out_overlap=0.
//   in_ready=0 while ASYNCRESET is high.
//  States: ACCUM (in_ready=1, out_valid=0), EMIT (in_ready=0, out_valid=1).
//  Accept = in_valid & in_ready. On accept in ACCUM:
//   fm   = {FIELD_W{1}} << in_off (WORD_W wide, zero-extended shift)
//   acc' = (acc & ~fm) | (in_field << in_off); bits outside fm are unchanged.
//   ovl' = ovl | |(mask & fm); mask' = mask | fm; count' = sat(count+1).
//   in_last=0: stay in ACCUM. in_last=1: go to EMIT, and register
//   out_word/out_count/out_overlap from acc'/count'/ovl'.
//  Latency: out_valid rises on the edge that accepts the last field
//   (visible the cycle after accept). No combinational path from in_* to out_*.
//  EMIT: out_word, out_count and out_overlap are held stable. in_valid is ignored.
//   When out_valid & out_ready: acc={FILL}, mask=0, count=0, ovl=0, state=ACCUM.
//   There is no same-cycle bypass, so the peak rate is one word per 2 cycles.
//  Offsets: in_off is unsigned. The same offset twice means the later field wins,
//   and out_overlap is set.
//  A word may have a single field. A word with no fields is never emitted.
//  out_* registers change only on the EMIT entry edge or on reset. In ACCUM,
//   out_word holds its last value (FILL after reset). Consumers use out_valid.
//  Mid-word reset: partial word discarded; next word starts from all-FILL with count 0.
//  Count saturation: the field after 2^CNT_W-1 still writes acc; count stays at max.
// TESTING
//  1 Reset: ASYNCRESET high mid-cycle -> out_valid=0, out_word=12'hFFF, in_ready=0
//    immediately; in_ready=1 after release.
//  2 Single field 6'h00, off=2, last=1 -> next cycle out_valid=1,
//    out_word=12'hF03, out_count=1, out_overlap=0.
//  3 Overlapping fields: 6'h2A off=0, then 6'h15 off=3 last -> out_word=12'hEAA,
//    out_count=2, out_overlap=1.
//  4 Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0,
//    out_word stable. On out_ready=1 -> ACCUM; next word starts from 12'hFFF.
//  5 Mid-word reset: fields off=0 and off=1 without last, then pulse ASYNCRESET,
//    then 6'h3F off=0 last -> out_word=12'hFFF, out_count=1, out_overlap=0.
//  6 Streaming: in_valid=1, in_last=1, out_ready=1 every cycle, offsets 0,1,2,3 ->
//    one word every 2 cycles with correct words. Scoreboard against a reference model.

Source files
------------

// File: rtl/slice_pack_sequencer.sv
// -----------------------------------------------------------------------------
// slice_pack_sequencer
//
// Purpose:
//   Assembles a WORD_W-bit word from a stream of FIELD_W-bit fields, each
//   written at a runtime bit offset into an accumulator pre-filled with FILL.
//   When the field flagged last is accepted, the assembled word, the number
//   of fields written and an overlap flag are latched and offered on a
//   valid/ready output. The block accepts no new fields until that word is
//   taken.
//
// Ports:
//   CLK          in   1        clock, rising edge
//   ASYNCRESET   in   1        asynchronous active-high reset
//   in_valid     in   1        field offered
//   in_ready     out  1        field accepted this cycle (ACCUM state)
//   in_field     in   FIELD_W  field data
//   in_off       in   OFF_W    LSB position of the field in the word
//   in_last      in   1        field closes the current word
//   out_valid    out  1        assembled word available (EMIT state)
//   out_ready    in   1        sink accepts word
//   out_word     out  WORD_W   assembled word
//   out_count    out  CNT_W    fields written (saturating)
//   out_overlap  out  1        a written bit was overwritten by a later field
// -----------------------------------------------------------------------------
module slice_pack_sequencer #(
  parameter int WORD_W  = 12,
  parameter int FIELD_W = 6,
  parameter int OFF_W   = 2,
  parameter int CNT_W   = 4,
  parameter bit FILL    = 1'b1
) (
  input  logic               CLK,
  input  logic               ASYNCRESET,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FIELD_W-1:0] in_field,
  input  logic [OFF_W-1:0]   in_off,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_word,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_overlap
);

  // Every offset must leave the whole field inside the word.
  generate
    if (((1 << OFF_W) - 1) + FIELD_W > WORD_W) begin : g_illegal
      $error("slice_pack_sequencer: max offset + FIELD_W exceeds WORD_W");
    end
  endgenerate

  localparam logic [WORD_W-1:0] FILL_WORD = {WORD_W{FILL}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [0:0] {ACCUM, EMIT} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   acc_q, acc_d;
  logic [WORD_W-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovl_q, ovl_d;
  logic [WORD_W-1:0]   out_word_q, out_word_d;
  logic [CNT_W-1:0]    out_count_q, out_count_d;
  logic                out_ovl_q, out_ovl_d;

  logic [WORD_W-1:0]   field_mask;
  logic [WORD_W-1:0]   field_data;
  logic [WORD_W-1:0]   acc_merge;
  logic [CNT_W-1:0]    count_inc;
  logic                accept;

  // Field footprint and data, zero-extended to word width before shifting.
  assign field_mask = WORD_W'({FIELD_W{1'b1}}) << in_off;
  assign field_data = WORD_W'(in_field) << in_off;

  // Bits inside the footprint take the new field; the rest keep their value.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_W; gi++) begin : g_merge
      assign acc_merge[gi] = field_mask[gi] ? field_data[gi] : acc_q[gi];
    end
  endgenerate

  assign count_inc = (count_q == CNT_MAX) ? CNT_MAX : count_q + 1'b1;

  // in_ready is forced low for as long as reset is held, not just after it.
  assign in_ready  = (state_q == ACCUM) && !ASYNCRESET;
  assign out_valid = (state_q == EMIT);
  assign accept    = in_valid && in_ready;

  assign out_word    = out_word_q;
  assign out_count   = out_count_q;
  assign out_overlap = out_ovl_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mask_d      = mask_q;
    count_d     = count_q;
    ovl_d       = ovl_q;
    out_word_d  = out_word_q;
    out_count_d = out_count_q;
    out_ovl_d   = out_ovl_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d   = acc_merge;
          mask_d  = mask_q | field_mask;
          count_d = count_inc;
          ovl_d   = ovl_q | (|(mask_q & field_mask));
          if (in_last) begin
            // Latch the post-update values so the emitted word includes
            // the closing field.
            state_d     = EMIT;
            out_word_d  = acc_merge;
            out_count_d = count_inc;
            out_ovl_d   = ovl_q | (|(mask_q & field_mask));
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_d = ACCUM;
          acc_d   = FILL_WORD;
          mask_d  = '0;
          count_d = '0;
          ovl_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q     <= ACCUM;
      acc_q       <= FILL_WORD;
      mask_q      <= '0;
      count_q     <= '0;
      ovl_q       <= 1'b0;
      out_word_q  <= FILL_WORD;
      out_count_q <= '0;
      out_ovl_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mask_q      <= mask_d;
      count_q     <= count_d;
      ovl_q       <= ovl_d;
      out_word_q  <= out_word_d;
      out_count_q <= out_count_d;
      out_ovl_q   <= out_ovl_d;
    end
  end

endmodule

// File: tb/tb_slice_pack_sequencer.sv
// -----------------------------------------------------------------------------
// tb_slice_pack_sequencer
//
// Directed stimulus with hand-computed expected words pushed into a queue;
// a monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_slice_pack_sequencer;

  logic        CLK;
  logic        ASYNCRESET;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_field;
  logic [1:0]  in_off;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_word;
  logic [3:0]  out_count;
  logic        out_overlap;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [11:0] word;
    logic [3:0]  count;
    logic        ovl;
  } exp_t;

  exp_t exp_q[$];

  slice_pack_sequencer #(
    .WORD_W(12), .FIELD_W(6), .OFF_W(2), .CNT_W(4), .FILL(1'b1)
  ) dut (
    .CLK(CLK),
    .ASYNCRESET(ASYNCRESET),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_field(in_field),
    .in_off(in_off),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word(out_word),
    .out_count(out_count),
    .out_overlap(out_overlap)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic push_exp(input logic [11:0] w, input logic [3:0] c,
                          input logic o);
    exp_t e;
    e.word  = w;
    e.count = c;
    e.ovl   = o;
    exp_q.push_back(e);
  endtask

  // Offer a field and return #1 after the edge that accepts it.
  // in_valid is left high so back-to-back calls stream.
  task automatic send(input logic [5:0] f, input logic [1:0] off,
                      input logic last);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_field = f;
    in_off   = off;
    in_last  = last;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Monitor: compare each handshaken word with the oldest expectation.
  always @(negedge CLK) begin
    if (ASYNCRESET === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {20'd0, out_word}, 32'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("word out: 0x%0h count %0d ovl %0d", out_word, out_count,
                 out_overlap);
        check("out_word", {20'd0, out_word}, {20'd0, e.word});
        check("out_count", {28'd0, out_count}, {28'd0, e.count});
        check("out_overlap", {31'd0, out_overlap}, {31'd0, e.ovl});
      end
    end
  end

  int start_cyc;

  initial begin
    ASYNCRESET = 1'b0;
    in_valid   = 1'b0;
    in_field   = '0;
    in_off     = '0;
    in_last    = 1'b0;
    out_ready  = 1'b1;

    // 1: reset asserted mid-cycle takes effect immediately
    #3 ASYNCRESET = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_word", {20'd0, out_word}, 32'hFFF);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_count", {28'd0, out_count}, 32'd0);
    repeat (2) @(posedge CLK);
    #1 ASYNCRESET = 1'b0;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // 2: single field
    push_exp(12'hF03, 4'd1, 1'b0);
    send(6'h00, 2'd2, 1'b1);
    idle();
    check("single_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge CLK); #1;

    // 3: overlapping fields
    push_exp(12'hEAA, 4'd2, 1'b1);
    send(6'h2A, 2'd0, 1'b0);
    send(6'h15, 2'd3, 1'b1);
    idle();
    @(posedge CLK); #1;

    // 4: backpressure holds the word and blocks input
    out_ready = 1'b0;
    push_exp(12'hFC0, 4'd1, 1'b0);
    send(6'h00, 2'd0, 1'b1);
    in_valid = 1'b1;
    in_field = 6'h3F;
    in_off   = 2'd0;
    in_last  = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_word", {20'd0, out_word}, 32'hFC0);
    end
    @(posedge CLK); #1;
    idle();
    out_ready = 1'b1;
    @(posedge CLK); #1;
    push_exp(12'hE07, 4'd1, 1'b0);
    send(6'h00, 2'd3, 1'b1);
    idle();
    @(posedge CLK); #1;

    // 5: mid-word reset discards the partial word
    send(6'h00, 2'd0, 1'b0);
    send(6'h00, 2'd1, 1'b0);
    idle();
    #2 ASYNCRESET = 1'b1;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    #4 ASYNCRESET = 1'b0;
    @(posedge CLK); #1;
    push_exp(12'hFFF, 4'd1, 1'b0);
    send(6'h3F, 2'd0, 1'b1);
    idle();
    @(posedge CLK); #1;

    // Count saturation: 17 fields, count stops at 15
    push_exp(12'hFFF, 4'd15, 1'b1);
    for (int i = 0; i < 16; i++) send(6'h00, 2'd0, 1'b0);
    send(6'h3F, 2'd0, 1'b1);
    idle();
    @(posedge CLK); #1;

    // 6: streaming, one word per 2 cycles
    push_exp(12'hFD5, 4'd1, 1'b0);
    push_exp(12'hF81, 4'd1, 1'b0);
    push_exp(12'hF3F, 4'd1, 1'b0);
    push_exp(12'hE97, 4'd1, 1'b0);
    start_cyc = cyc;
    send(6'h15, 2'd0, 1'b1);
    send(6'h00, 2'd1, 1'b1);
    send(6'h0F, 2'd2, 1'b1);
    send(6'h12, 2'd3, 1'b1);
    check("stream_cycles", cyc - start_cyc, 32'd7);
    idle();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge CLK);
    @(negedge CLK);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
